// File: rtl/clock_adjust_ctrl.sv
// Time-of-day counter (BCD hh:mm:ss) with a key-driven field-adjust FSM
// and an inactivity timeout that drops back to run mode.
module clock_adjust_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_1hz_tick,
    input  logic       i_key_mode,
    input  logic       i_key_inc,
    output logic [3:0] o_hour_h,
    output logic [3:0] o_hour_l,
    output logic [3:0] o_minut_h,
    output logic [3:0] o_minut_l,
    output logic [3:0] o_second_h,
    output logic [3:0] o_second_l,
    output logic [1:0] o_adjust_cnt,
    output logic       o_day_pulse
);

    localparam int unsigned FIELD_W = 8;
    localparam int unsigned TO_W    = 8;
    localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(TIMEOUT_S);
    localparam bit TO_EN = (TIMEOUT_S != 0);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        ADJ_SEC  = 2'b01,
        ADJ_MIN  = 2'b10,
        ADJ_HOUR = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [FIELD_W-1:0]  sec_q, sec_d;
    logic [FIELD_W-1:0]  min_q, min_d;
    logic [FIELD_W-1:0]  hour_q, hour_d;
    logic                day_q, day_d;
    logic [TO_W-1:0]     to_q, to_d;

    // Two-digit BCD increment over 00..59 with wrap to 00.
    function automatic logic [FIELD_W-1:0] inc_sexa(input logic [FIELD_W-1:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two-digit BCD increment over 00..23 with wrap to 00.
    function automatic logic [FIELD_W-1:0] inc_hour(input logic [FIELD_W-1:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // State, time fields, day pulse and timeout counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            day_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            to_q    <= to_d;
        end
    end

    // Next-state and datapath; the action is chosen by the state held before the edge.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = 1'b0;
        to_d    = to_q;

        case (state_q)
            RUN: begin
                to_d = '0;
                if (i_1hz_tick) begin
                    sec_d = inc_sexa(sec_q);
                    if (sec_q == 8'h59) begin
                        min_d = inc_sexa(min_q);
                        if (min_q == 8'h59) begin
                            hour_d = inc_hour(hour_q);
                            day_d  = (hour_q == 8'h23);
                        end
                    end
                end
                if (i_key_mode) state_d = ADJ_SEC;
            end
            default: begin
                if (i_key_mode) begin
                    to_d = '0;
                    case (state_q)
                        ADJ_SEC: state_d = ADJ_MIN;
                        ADJ_MIN: state_d = ADJ_HOUR;
                        default: state_d = RUN;
                    endcase
                end else if (i_key_inc) begin
                    to_d = '0;
                    case (state_q)
                        ADJ_SEC: sec_d  = inc_sexa(sec_q);
                        ADJ_MIN: min_d  = inc_sexa(min_q);
                        default: hour_d = inc_hour(hour_q);
                    endcase
                end else if (i_1hz_tick) begin
                    if (TO_EN && (({1'b0, to_q} + (TO_W+1)'(1)) == TO_LIMIT)) begin
                        state_d = RUN;
                        to_d    = '0;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
        endcase
    end

    // Outputs come straight from the registers.
    assign o_hour_h     = hour_q[7:4];
    assign o_hour_l     = hour_q[3:0];
    assign o_minut_h    = min_q[7:4];
    assign o_minut_l    = min_q[3:0];
    assign o_second_h   = sec_q[7:4];
    assign o_second_l   = sec_q[3:0];
    assign o_adjust_cnt = state_q;
    assign o_day_pulse  = day_q;

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Directed bench for clock_adjust_ctrl with a seconds-of-day reference model.
module tb_clock_adjust_ctrl;

    localparam int unsigned TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       rst, tick, kmode, kinc;
    logic [3:0] hh, hl, mh, ml, sh, sl;
    logic [1:0] adj;
    logic       day;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Reference model: time as seconds of day, mode as 0..3.
    int m_sec  = 0;
    int m_mode = 0;
    int m_to   = 0;
    bit m_day  = 1'b0;

    always #5 clk = ~clk;

    clock_adjust_ctrl #(.TIMEOUT_S(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_1hz_tick   (tick),
        .i_key_mode   (kmode),
        .i_key_inc    (kinc),
        .o_hour_h     (hh),
        .o_hour_l     (hl),
        .o_minut_h    (mh),
        .o_minut_l    (ml),
        .o_second_h   (sh),
        .o_second_l   (sl),
        .o_adjust_cnt (adj),
        .o_day_pulse  (day)
    );

    function automatic logic [23:0] bcd_of(input int s);
        int h, m, c;
        h = s / 3600;
        m = (s / 60) % 60;
        c = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [23:0] dut_time();
        return {hh, hl, mh, ml, sh, sl};
    endfunction

    // Model update on every clock edge from the same inputs the DUT samples.
    always @(posedge clk) begin
        int h, m, c;
        if (rst) begin
            m_sec = 0; m_mode = 0; m_to = 0; m_day = 1'b0;
        end else begin
            m_day = 1'b0;
            if (m_mode == 0) begin
                if (tick) begin
                    if (m_sec == 86399) begin
                        m_sec = 0;
                        m_day = 1'b1;
                    end else begin
                        m_sec = m_sec + 1;
                    end
                end
                if (kmode) begin
                    m_mode = 1;
                    m_to   = 0;
                end
            end else if (kmode) begin
                m_mode = (m_mode + 1) % 4;
                m_to   = 0;
            end else if (kinc) begin
                m_to = 0;
                h = m_sec / 3600;
                m = (m_sec / 60) % 60;
                c = m_sec % 60;
                if (m_mode == 1) c = (c + 1) % 60;
                else if (m_mode == 2) m = (m + 1) % 60;
                else h = (h + 1) % 24;
                m_sec = h * 3600 + m * 60 + c;
            end else if (tick) begin
                m_to = m_to + 1;
                if (TIMEOUT != 0 && m_to == int'(TIMEOUT)) begin
                    m_mode = 0;
                    m_to   = 0;
                end
            end
        end
    end

    task automatic model_cmp();
        logic [26:0] act, exp;
        if (!chk_en) return;
        act = {dut_time(), adj, day};
        exp = {bcd_of(m_sec), 2'(m_mode), m_day};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t actual=%h required=%h", $time, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock with the given pulses; outputs are inspected 1 time unit after the edge.
    task automatic apply(input bit t, input bit m, input bit i);
        tick = t; kmode = m; kinc = i;
        @(posedge clk);
        #1;
        tick = 1'b0; kmode = 1'b0; kinc = 1'b0;
        model_cmp();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; kmode = 1'b0; kinc = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Reset state.
        check("reset_time", 32'(dut_time()), 32'h000000);
        check("reset_adj", 32'(adj), 32'd0);
        check("reset_day", 32'(day), 32'd0);

        // 61 ticks in run mode.
        for (int k = 0; k < 61; k++) begin
            apply(1, 0, 0);
            apply(0, 0, 0);
        end
        check("run61_time", 32'(dut_time()), 32'h000101);
        check("run61_adj", 32'(adj), 32'd0);

        // Preset 23:59:58 through the adjust fields, then roll over midnight.
        do_reset();
        apply(0, 1, 0);
        for (int k = 0; k < 58; k++) apply(0, 0, 1);
        apply(0, 1, 0);
        for (int k = 0; k < 59; k++) apply(0, 0, 1);
        apply(0, 1, 0);
        for (int k = 0; k < 23; k++) apply(0, 0, 1);
        check("preset_time", 32'(dut_time()), 32'h235958);
        apply(0, 1, 0);
        check("preset_run", 32'(adj), 32'd0);
        apply(1, 0, 0);
        check("tick_235959", 32'(dut_time()), 32'h235959);
        check("no_day_early", 32'(day), 32'd0);
        apply(1, 0, 0);
        check("midnight_time", 32'(dut_time()), 32'h000000);
        check("day_pulse_hi", 32'(day), 32'd1);
        apply(0, 0, 0);
        check("day_pulse_lo", 32'(day), 32'd0);

        // Seconds adjust: 61 increments wrap to 01, interleaved ticks frozen.
        do_reset();
        apply(0, 1, 0);
        for (int k = 0; k < 61; k++) begin
            apply(0, 0, 1);
            if (k % 5 == 4) apply(1, 0, 0);
        end
        check("adjsec_time", 32'(dut_time()), 32'h000001);
        check("adjsec_adj", 32'(adj), 32'd1);

        // Hour wrap 23->00 in adjust without carry or day pulse, then resume.
        do_reset();
        apply(0, 1, 0);
        for (int k = 0; k < 7; k++) apply(0, 0, 1);
        apply(0, 1, 0);
        for (int k = 0; k < 30; k++) apply(0, 0, 1);
        apply(0, 1, 0);
        for (int k = 0; k < 23; k++) apply(0, 0, 1);
        check("hour23_time", 32'(dut_time()), 32'h233007);
        apply(0, 0, 1);
        check("hourwrap_time", 32'(dut_time()), 32'h003007);
        check("hourwrap_day", 32'(day), 32'd0);
        apply(0, 1, 0);
        check("hourwrap_adj", 32'(adj), 32'd0);
        apply(1, 0, 0);
        check("resume_time", 32'(dut_time()), 32'h003008);

        // Timeout after 10 idle ticks.
        do_reset();
        apply(0, 1, 0);
        for (int k = 0; k < 9; k++) begin
            apply(1, 0, 0);
            apply(0, 0, 0);
        end
        check("to9_adj", 32'(adj), 32'd1);
        apply(1, 0, 0);
        check("to10_adj", 32'(adj), 32'd0);
        check("to10_time", 32'(dut_time()), 32'h000000);

        // Increment after tick 5 restarts the timeout: exit on tick 15.
        apply(0, 1, 0);
        for (int k = 0; k < 5; k++) apply(1, 0, 0);
        apply(0, 0, 1);
        for (int k = 0; k < 9; k++) apply(1, 0, 0);
        check("to14_adj", 32'(adj), 32'd1);
        apply(1, 0, 0);
        check("to15_adj", 32'(adj), 32'd0);
        check("to15_time", 32'(dut_time()), 32'h000001);

        // Tick coinciding with mode: applied leaving run, dropped returning to run.
        do_reset();
        apply(1, 1, 0);
        check("tick_leave_time", 32'(dut_time()), 32'h000001);
        check("tick_leave_adj", 32'(adj), 32'd1);
        apply(0, 1, 0);
        apply(0, 1, 0);
        apply(1, 1, 0);
        check("tick_return_time", 32'(dut_time()), 32'h000001);
        check("tick_return_adj", 32'(adj), 32'd0);
        apply(1, 0, 0);
        check("tick_after_return", 32'(dut_time()), 32'h000002);

        // Mode beats inc in ADJ_MIN; reset during ADJ_HOUR.
        do_reset();
        apply(0, 1, 0);
        apply(0, 1, 0);
        for (int k = 0; k < 5; k++) apply(0, 0, 1);
        check("min05_time", 32'(dut_time()), 32'h000500);
        apply(0, 1, 1);
        check("mode_inc_adj", 32'(adj), 32'd3);
        check("mode_inc_time", 32'(dut_time()), 32'h000500);
        rst = 1'b1;
        apply(1, 1, 1);
        rst = 1'b0;
        check("midadj_rst_time", 32'(dut_time()), 32'h000000);
        check("midadj_rst_adj", 32'(adj), 32'd0);
        apply(1, 0, 0);
        check("post_rst_tick", 32'(dut_time()), 32'h000001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
